// File: rtl/ahb_rr_out_arb.sv
// ahb_rr_out_arb: round-robin arbiter for one AHB output port of a bus matrix.
// Chooses which of three input stages drives the output port. The grant is held
// for locked transfers and, when AHB_RR_BURST_HOLD_EN is defined, for the full
// length of defined-length bursts.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   req_port0..2           input-stage requests for this output port
//   HREADYM                transfer done on output port; sole enable for state
//   HSELM, HTRANSM,
//   HBURSTM, HMASTLOCKM    control currently driven on the output port
//   addr_in_port           index of the granted input port (0..2)
//   no_port                high when no input port is granted
//   burst_hold             high while a defined-length burst holds the grant
//
// Build option: define AHB_RR_BURST_HOLD_EN to enable burst-length grant holding.
module ahb_rr_out_arb (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       req_port0,
  input  logic       req_port1,
  input  logic       req_port2,
  input  logic       HREADYM,
  input  logic       HSELM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  input  logic       HMASTLOCKM,
  output logic [1:0] addr_in_port,
  output logic       no_port,
  output logic       burst_hold
);

  localparam int unsigned PORT_W  = 2;
  localparam int unsigned N_PORTS = 3;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  logic [PORT_W-1:0]  ptr_q, ptr_d;
  logic [PORT_W-1:0]  addr_d;
  logic               no_d;
  logic [N_PORTS-1:0] req_vec;
  logic [PORT_W-1:0]  cand1, cand2, grant;
  logic               found;
  logic               hold_grant;

  // Next index in cyclic order 0 -> 1 -> 2 -> 0.
  function automatic logic [PORT_W-1:0] next3(input logic [PORT_W-1:0] p);
    return (p == PORT_W'(2)) ? PORT_W'(0) : PORT_W'(p + PORT_W'(1));
  endfunction

  function automatic logic port_req(input logic [N_PORTS-1:0] v,
                                    input logic [PORT_W-1:0] idx);
    logic r;
    case (idx)
      2'd0:    r = v[0];
      2'd1:    r = v[1];
      2'd2:    r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

`ifdef AHB_RR_BURST_HOLD_EN
  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Beats remaining in a defined-length burst after the NONSEQ beat.
  always_comb begin
    cnt_d = cnt_q;
    if (HREADYM) begin
      case (HTRANSM)
        TRANS_NONSEQ: begin
          case (HBURSTM[2:1])
            2'b01:   cnt_d = CNT_W'(3);
            2'b10:   cnt_d = CNT_W'(7);
            2'b11:   cnt_d = CNT_W'(15);
            default: cnt_d = CNT_W'(0);
          endcase
        end
        TRANS_SEQ:  if (cnt_q != CNT_W'(0)) cnt_d = cnt_q - CNT_W'(1);
        TRANS_BUSY: cnt_d = cnt_q;
        default:    cnt_d = CNT_W'(0);
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q      <= CNT_W'(0);
      burst_hold <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      burst_hold <= (cnt_d != CNT_W'(0));
    end
  end

  assign hold_grant = HMASTLOCKM || (burst_hold && (HTRANSM != TRANS_IDLE));
`else
  logic unused_burst;
  assign unused_burst = ^HBURSTM;
  assign burst_hold   = 1'b0;
  assign hold_grant   = HMASTLOCKM;
`endif

  // Request vector: the currently granted port keeps requesting while its
  // transfer is still active on the output port.
  always_comb begin
    req_vec = {req_port2, req_port1, req_port0};
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (!no_port && HSELM && (HTRANSM != TRANS_IDLE) &&
          (addr_in_port == PORT_W'(i)))
        req_vec[i] = 1'b1;
    end
  end

  // Round-robin search starting after the last granted port.
  always_comb begin
    cand1 = next3(ptr_q);
    cand2 = next3(cand1);
    found = 1'b1;
    grant = cand1;
    if (port_req(req_vec, cand1))      grant = cand1;
    else if (port_req(req_vec, cand2)) grant = cand2;
    else if (port_req(req_vec, ptr_q)) grant = ptr_q;
    else                               found = 1'b0;
  end

  // Next grant state; everything freezes while HREADYM is low.
  always_comb begin
    addr_d = addr_in_port;
    no_d   = no_port;
    ptr_d  = ptr_q;
    if (HREADYM && !hold_grant) begin
      if (found) begin
        addr_d = grant;
        no_d   = 1'b0;
        ptr_d  = grant;
      end else if (!HSELM) begin
        no_d   = 1'b1;
      end
    end
  end

  // Reset pointer at 2 so port 0 has first priority.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= PORT_W'(0);
      no_port      <= 1'b1;
      ptr_q        <= PORT_W'(2);
    end else begin
      addr_in_port <= addr_d;
      no_port      <= no_d;
      ptr_q        <= ptr_d;
    end
  end

endmodule

// File: tb/tb_ahb_rr_out_arb.sv
// Scoreboard bench for ahb_rr_out_arb: each stimulus step pushes the expected
// grant outputs; a monitor pops and compares after every clock edge or reset.
module tb_ahb_rr_out_arb;

  logic       HCLK;
  logic       HRESETn;
  logic       req_port0, req_port1, req_port2;
  logic       HREADYM, HSELM, HMASTLOCKM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic       burst_hold;

  localparam logic [1:0] IDLE = 2'b00, NSQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101, INCR16 = 3'b111;

`ifdef AHB_RR_BURST_HOLD_EN
  localparam logic HE = 1'b1;
`else
  localparam logic HE = 1'b0;
`endif

  typedef struct {
    logic [1:0] addr;
    logic       no;
    logic       hold;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ahb_rr_out_arb dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_port0(req_port0), .req_port1(req_port1), .req_port2(req_port2),
    .HREADYM(HREADYM), .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM),
    .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr_in_port), .no_port(no_port), .burst_hold(burst_hold)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Monitor: one expected entry per clock edge or reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge HCLK or negedge HRESETn);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (addr_in_port !== e.addr || no_port !== e.no || burst_hold !== e.hold) begin
          errors++;
          $display("FAIL %s: got addr=%0d no_port=%0b hold=%0b, expected addr=%0d no_port=%0b hold=%0b",
                   e.name, addr_in_port, no_port, burst_hold, e.addr, e.no, e.hold);
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] ea, input logic en, input logic eh, input string nm);
    exp_t e;
    e.addr = ea; e.no = en; e.hold = eh; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs (at posedge+2) and expect outputs after the next edge.
  task automatic step(input logic r0, input logic r1, input logic r2,
                      input logic rdy, input logic sel, input logic [1:0] tr,
                      input logic [2:0] bu, input logic lk,
                      input logic [1:0] ea, input logic en, input logic eh,
                      input string nm);
    req_port0 = r0; req_port1 = r1; req_port2 = r2;
    HREADYM = rdy; HSELM = sel; HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk;
    push_exp(ea, en, eh, nm);
    @(posedge HCLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0;
    req_port0 = 0; req_port1 = 0; req_port2 = 0;
    HREADYM = 1; HSELM = 0; HTRANSM = IDLE; HBURSTM = SINGLE; HMASTLOCKM = 0;
    #2;
    push_exp(2'd0, 1'b1, 1'b0, "reset_state");
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;

    // Round robin with all requesting: 0,1,2,0
    step(1,1,1, 1,1,NSQ,SINGLE,0, 2'd0,0,0, "rr_0");
    step(1,1,1, 1,1,NSQ,SINGLE,0, 2'd1,0,0, "rr_1");
    step(1,1,1, 1,1,NSQ,SINGLE,0, 2'd2,0,0, "rr_2");
    step(1,1,1, 1,1,NSQ,SINGLE,0, 2'd0,0,0, "rr_3");

    // HREADYM low: everything frozen, burst counter must not load
    step(0,1,0, 0,1,NSQ,INCR8,0,  2'd0,0,0, "freeze_0");
    step(0,0,1, 0,0,NSQ,INCR8,0,  2'd0,0,0, "freeze_1");
    step(1,1,1, 0,1,IDLE,SINGLE,0, 2'd0,0,0, "freeze_2");
    step(0,0,0, 0,0,IDLE,SINGLE,0, 2'd0,0,0, "freeze_3");

    // Lock holds port 2 for 5 cycles
    step(0,0,1, 1,1,NSQ,SINGLE,0, 2'd2,0,0, "lock_grant2");
    for (int i = 0; i < 5; i++)
      step(1,1,0, 1,1,NSQ,SINGLE,1, 2'd2,0,0, $sformatf("lock_hold_%0d", i));
    step(1,1,0, 1,1,NSQ,SINGLE,0, 2'd0,0,0, "lock_release");

    // No requests: HSELM=1 retains, HSELM=0 drops to no_port
    step(0,1,0, 1,1,NSQ,SINGLE,0, 2'd1,0,0, "idle_grant1");
    step(0,0,0, 1,1,IDLE,SINGLE,0, 2'd1,0,0, "idle_sel1_keep");
    step(0,0,0, 1,0,IDLE,SINGLE,0, 2'd1,1,0, "idle_sel0_noport");
    step(0,0,0, 1,1,IDLE,SINGLE,0, 2'd1,1,0, "idle_sel1_noport_keep");

    // INCR4 on port 1 with port 0 waiting
    step(0,1,0, 1,1,NSQ,INCR4,0, 2'd1,0,HE, "incr4_nonseq");
`ifdef AHB_RR_BURST_HOLD_EN
    step(1,0,0, 1,1,SEQ,INCR4,0, 2'd1,0,1, "incr4_seq1");
    step(1,0,0, 1,1,SEQ,INCR4,0, 2'd1,0,1, "incr4_seq2");
    step(1,0,0, 1,1,SEQ,INCR4,0, 2'd1,0,0, "incr4_seq3");
`else
    step(1,0,0, 1,1,SEQ,INCR4,0, 2'd0,0,0, "incr4_seq1");
    step(1,0,0, 1,1,SEQ,INCR4,0, 2'd0,0,0, "incr4_seq2");
    step(1,0,0, 1,1,SEQ,INCR4,0, 2'd0,0,0, "incr4_seq3");
`endif
    step(1,0,0, 1,1,IDLE,INCR4,0, 2'd0,0,0, "incr4_rearb");

    // INCR8 terminated early by IDLE
    step(1,0,0, 1,1,NSQ,INCR8,0, 2'd0,0,HE, "incr8_nonseq");
`ifdef AHB_RR_BURST_HOLD_EN
    step(1,0,1, 1,1,SEQ,INCR8,0, 2'd0,0,1, "incr8_seq1");
    step(1,0,1, 1,1,SEQ,INCR8,0, 2'd0,0,1, "incr8_seq2");
`else
    step(1,0,1, 1,1,SEQ,INCR8,0, 2'd2,0,0, "incr8_seq1");
    step(1,0,1, 1,1,SEQ,INCR8,0, 2'd0,0,0, "incr8_seq2");
`endif
    step(1,0,1, 1,1,IDLE,INCR8,0, 2'd2,0,0, "incr8_idle_term");

    // INCR16 on port 2, reset at counter 9
    step(0,0,1, 1,1,NSQ,INCR16,0, 2'd2,0,HE, "incr16_nonseq");
    for (int i = 0; i < 6; i++) begin
`ifdef AHB_RR_BURST_HOLD_EN
      step(1,1,0, 1,1,SEQ,INCR16,0, 2'd2,0,1, $sformatf("incr16_seq%0d", i + 1));
`else
      step(1,1,0, 1,1,SEQ,INCR16,0, ((i % 2) == 0) ? 2'd0 : 2'd1,0,0,
           $sformatf("incr16_seq%0d", i + 1));
`endif
    end
    push_exp(2'd0, 1'b1, 1'b0, "reset_mid_burst");
    HREADYM = 1'b0;
    HRESETn = 1'b0;
    @(posedge HCLK);
    #2;
    HRESETn = 1'b1;

    // First arbitration after reset starts from pointer 2; no stale hold
    step(0,1,1, 1,1,SEQ,INCR16,0, 2'd1,0,0, "post_reset_grant");
    step(1,1,1, 1,1,NSQ,SINGLE,0, 2'd2,0,0, "post_reset_rr");

    repeat (3) @(posedge HCLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_rr_out_arb.md
AHB_RR_OUT_ARB -- requirements
Module: ahb_rr_out_arb

Interface
REQ-001 SHALL have port HCLK  input  1  AHB system clock; all state on rising edge.
REQ-002 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports req_port0, req_port1, req_port2  input  1 each  input-stage request for this output port.
REQ-004 SHALL have port HREADYM  input  1  transfer done on output port; sole enable for arbitration state.
REQ-005 SHALL have port HSELM  input  1  slave select currently driven on output port.
REQ-006 SHALL have port HTRANSM  input  2  transfer type driven on output port (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 SHALL have port HBURSTM  input  3  burst type driven on output port.
REQ-008 SHALL have port HMASTLOCKM  input  1  locked-transfer indication on output port.
REQ-009 SHALL have port addr_in_port  output  2  index of granted input port (0..2); value 3 never driven.
REQ-010 SHALL have port no_port  output  1  high when no input port is granted.
REQ-011 SHALL have port burst_hold  output  1  high while a defined-length burst holds the grant.

Function
REQ-012 SHALL update addr_in_port, no_port, burst counter and RR pointer only on HCLK rising edges with HREADYM=1; with HREADYM=0 all SHALL hold.
REQ-013 SHALL treat port i as requesting when req_port_i=1, or when i=addr_in_port, no_port=0, HSELM=1 and HTRANSM!=IDLE.
REQ-014 SHALL keep the current grant (addr_in_port, no_port unchanged) when HMASTLOCKM=1, regardless of requests.
REQ-015 SHALL keep the current grant when burst_hold=1 and HTRANSM!=IDLE.
REQ-016 Otherwise SHALL grant the first requesting port in cyclic order ptr+1, ptr+2, ptr (mod 3), where ptr is the RR pointer; no_port SHALL be 0.
REQ-017 With no requesting port and HSELM=1 SHALL keep addr_in_port and no_port unchanged; with HSELM=0 SHALL set no_port=1 and keep addr_in_port.
REQ-018 SHALL load ptr with the newly granted index on every update where a grant is issued under REQ-016.
REQ-019 Burst counter (4 bits): on an enabled edge with HTRANSM=NONSEQ, load 3 for HBURSTM 010/011, 7 for 100/101, 15 for 110/111, 0 for 000/001.
REQ-020 Burst counter: on an enabled edge with HTRANSM=SEQ and counter>0, decrement by 1; BUSY SHALL leave it unchanged; IDLE SHALL clear it to 0 (early termination).
REQ-021 burst_hold SHALL equal (counter!=0); the edge that decrements the counter to 0 SHALL allow re-arbitration on the next enabled edge.
REQ-022 Simultaneous requests from all ports with ptr=p SHALL produce grants p+1, p+2, p, ... on successive arbitration points.

Reset
REQ-023 On HRESETn=0 SHALL asynchronously set addr_in_port=0, no_port=1, counter=0, burst_hold=0, ptr=2 (port 0 first priority).
REQ-024 Reset asserted mid-burst or mid-lock SHALL discard hold state; first post-reset arbitration SHALL follow REQ-016 from ptr=2.

Configuration
REQ-025 Macro AHB_RR_BURST_HOLD_EN: when defined, REQ-015 and REQ-019..021 SHALL be implemented as stated.
REQ-026 When AHB_RR_BURST_HOLD_EN is undefined, counter logic SHALL be absent, burst_hold SHALL be tied 0, and re-arbitration SHALL occur on every enabled edge not held by HMASTLOCKM.

Verification
REQ-027 Reset, then req_port0..2=1 continuously, HTRANSM=NONSEQ SINGLE, HREADYM=1 -> addr_in_port sequence 0,1,2,0 on successive edges, no_port=0.
REQ-028 (macro on) Port 1 granted, INCR4 NONSEQ then 3 SEQ with req_port0=1 -> burst_hold=1 for 3 beats, addr_in_port=1 until counter 0, then 2 or 0 per ptr.
REQ-029 Port 2 granted, HMASTLOCKM=1 for 5 cycles with req_port0/1=1 -> addr_in_port=2 throughout; switches to 0 one edge after HMASTLOCKM=0.
REQ-030 All requests 0, HSELM=0 -> no_port=1 next edge; HSELM=1 with HTRANSM=IDLE -> grant retained, no_port=0.
REQ-031 HREADYM=0 for 4 cycles while requests change -> outputs frozen; INCR8 burst terminated by IDLE after 2 beats -> burst_hold=0 next edge.
REQ-032 HRESETn pulsed low mid-INCR16 at counter=9 -> immediately addr_in_port=0, no_port=1, burst_hold=0.
